// File: rtl/fetch_pc_unit_if.sv
// Fetch/resolve bus between the fetch PC unit and the rest of the pipeline.
// The slave modport is the fetch unit's view of the bus.
interface fetch_pc_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            en;
   logic [XLEN-1:0] pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            res_valid;
   logic [XLEN-1:0] res_pc;
   logic            res_taken;
   logic [XLEN-1:0] res_target;
   logic            res_pred_taken;
   logic [XLEN-1:0] res_pred_target;
   logic            mispredict;

   modport master (
      output en, res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
      input  pc, pred_taken, pred_target, mispredict
   );

   modport slave (
      input  en, res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
      output pc, pred_taken, pred_target, mispredict
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters), mispredict
// redirect and saturating branch statistics.
module fetch_pc_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] PC_INIT     = '0,
   parameter int unsigned     BTB_ENTRIES = 16,
   parameter int unsigned     CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  nrst,
   fetch_pc_unit_if.slave        bus,
   output logic [CNT_W-1:0]      branch_cnt,
   output logic [CNT_W-1:0]      mispred_cnt
);
   localparam int unsigned     IDX  = $clog2(BTB_ENTRIES);
   localparam int unsigned     TAGW = XLEN - IDX - 2;
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("BTB_ENTRIES must be a power of 2 and at least 2");
   end

   logic            btb_valid [BTB_ENTRIES];
   logic [TAGW-1:0] btb_tag   [BTB_ENTRIES];
   logic [XLEN-1:0] btb_tgt   [BTB_ENTRIES];
   logic [1:0]      btb_ctr   [BTB_ENTRIES];

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

   logic [IDX-1:0]  f_idx, r_idx;
   logic [TAGW-1:0] f_tag, r_tag;
   logic            f_hit, r_hit;

   always_comb begin
      f_idx = pc_q[IDX+1:2];
      f_tag = pc_q[XLEN-1:IDX+2];
      f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
      r_idx = bus.res_pc[IDX+1:2];
      r_tag = bus.res_pc[XLEN-1:IDX+2];
      r_hit = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
   end

   always_comb begin
      bus.pc          = pc_q;
      bus.pred_taken  = f_hit && btb_ctr[f_idx][1];
      bus.pred_target = f_hit ? btb_tgt[f_idx] : pc_q + FOUR;
      bus.mispredict  = bus.res_valid &&
                        ((bus.res_taken != bus.res_pred_taken) ||
                         (bus.res_taken && (bus.res_target != bus.res_pred_target)));
   end

   // A redirect from a resolving branch outranks both the stall and the prediction.
   always_comb begin
      pc_d = pc_q;
      if (bus.mispredict) begin
         pc_d    = bus.res_taken ? bus.res_target : bus.res_pc + FOUR;
         pc_d[0] = 1'b0;
      end else if (bus.en) begin
         pc_d    = bus.pred_taken ? bus.pred_target : pc_q + FOUR;
         pc_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pc_q          <= PC_INIT;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pc_q <= pc_d;
         if (bus.res_valid && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         if (bus.mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
            btb_valid[i] <= 1'b0;
            btb_tag[i]   <= '0;
            btb_tgt[i]   <= '0;
            btb_ctr[i]   <= 2'b00;
         end
      end else if (bus.res_valid) begin
         if (r_hit) begin
            if (bus.res_taken) begin
               if (btb_ctr[r_idx] != 2'b11) btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
               btb_tgt[r_idx] <= bus.res_target;
            end else if (btb_ctr[r_idx] != 2'b00) begin
               btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
            end
         end else if (bus.res_taken) begin
            // Allocation replaces whatever aliased into this slot.
            btb_valid[r_idx] <= 1'b1;
            btb_tag[r_idx]   <= r_tag;
            btb_tgt[r_idx]   <= bus.res_target;
            btb_ctr[r_idx]   <= 2'b10;
         end
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized checks of fetch_pc_unit against a behavioural BTB model;
// a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_fetch_pc_unit;
   localparam int unsigned ENTRIES = 16;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   fetch_pc_unit_if #(.XLEN(32)) ifa ();
   fetch_pc_unit_if #(.XLEN(32)) ifb ();

   logic [31:0] br_a, mis_a;
   logic [1:0]  br_b, mis_b;

   fetch_pc_unit #(.XLEN(32), .PC_INIT(32'h0), .BTB_ENTRIES(ENTRIES), .CNT_W(32)) dut (
      .clk(clk), .nrst(nrst), .bus(ifa), .branch_cnt(br_a), .mispred_cnt(mis_a)
   );
   fetch_pc_unit #(.XLEN(32), .PC_INIT(32'h0), .BTB_ENTRIES(ENTRIES), .CNT_W(2)) dut_s (
      .clk(clk), .nrst(nrst), .bus(ifb), .branch_cnt(br_b), .mispred_cnt(mis_b)
   );

   assign ifb.en              = ifa.en;
   assign ifb.res_valid       = ifa.res_valid;
   assign ifb.res_pc          = ifa.res_pc;
   assign ifb.res_taken       = ifa.res_taken;
   assign ifb.res_target      = ifa.res_target;
   assign ifb.res_pred_taken  = ifa.res_pred_taken;
   assign ifb.res_pred_target = ifa.res_pred_target;

   int checks = 0;
   int errors = 0;

   // Reference model: BTB as plain arrays indexed by word address modulo depth.
   bit          m_valid [ENTRIES];
   logic [31:0] m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [31:0] m_pc;
   longint      m_br, m_mis;

   function automatic int m_idx(input logic [31:0] a);
      return int'((a / 4) % ENTRIES);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a / (4 * ENTRIES));
   endfunction

   function automatic bit m_ptaken(input logic [31:0] a);
      return m_hit(a) && (m_ctr[m_idx(a)] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt(input logic [31:0] a);
      return m_hit(a) ? m_tgt[m_idx(a)] : a + 32'd4;
   endfunction

   function automatic bit m_misp();
      if (!ifa.res_valid) return 1'b0;
      if (ifa.res_taken != ifa.res_pred_taken) return 1'b1;
      return ifa.res_taken && (ifa.res_target != ifa.res_pred_target);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < int'(ENTRIES); i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 0;
      end
      m_pc  = 32'h0;
      m_br  = 0;
      m_mis = 0;
   endtask

   task automatic m_edge();
      logic [31:0] nxt;
      int i;
      nxt = m_pc;
      if (m_misp()) nxt = ifa.res_taken ? ifa.res_target : ifa.res_pc + 32'd4;
      else if (ifa.en) nxt = m_ptaken(m_pc) ? m_ptgt(m_pc) : m_pc + 32'd4;
      if (m_misp() || ifa.en) nxt = nxt & ~32'd1;
      if (m_misp()) m_mis++;
      if (ifa.res_valid) begin
         m_br++;
         i = m_idx(ifa.res_pc);
         if (m_hit(ifa.res_pc)) begin
            if (ifa.res_taken) begin
               m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
               m_tgt[i] = ifa.res_target;
            end else begin
               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (ifa.res_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = ifa.res_pc / (4 * ENTRIES);
            m_tgt[i]   = ifa.res_target;
            m_ctr[i]   = 2;
         end
      end
      m_pc = nxt;
   endtask

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic set_res(input bit rv, input logic [31:0] rpc, input bit rt,
                          input logic [31:0] rtgt, input bit rpt, input logic [31:0] rptgt);
      ifa.res_valid       = rv;
      ifa.res_pc          = rpc;
      ifa.res_taken       = rt;
      ifa.res_target      = rtgt;
      ifa.res_pred_taken  = rpt;
      ifa.res_pred_target = rptgt;
   endtask

   // Compare every output against the model, then advance one edge.
   task automatic cycle();
      longint sb, sm;
      #1;
      sb = (m_br > 3) ? 3 : m_br;
      sm = (m_mis > 3) ? 3 : m_mis;
      check("pc", ifa.pc, m_pc);
      check("pred_taken", ifa.pred_taken, m_ptaken(m_pc));
      check("pred_target", ifa.pred_target, m_ptgt(m_pc));
      check("mispredict", ifa.mispredict, m_misp());
      check("branch_cnt", br_a, m_br[31:0]);
      check("mispred_cnt", mis_a, m_mis[31:0]);
      check("small_pc", ifb.pc, m_pc);
      check("small_branch_cnt", br_b, sb[1:0]);
      check("small_mispred_cnt", mis_b, sm[1:0]);
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rpc, rtgt;
      bit rv, rt;
      ifa.en = 1'b0;
      set_res(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      m_reset();

      // Reset state
      #12;
      check("rst_pc", ifa.pc, 32'h0);
      check("rst_pred_taken", ifa.pred_taken, 1'b0);
      check("rst_pred_target", ifa.pred_target, 32'h4);
      check("rst_cnts", {br_a, mis_a}, 64'h0);
      @(negedge clk);
      nrst = 1'b1;

      // Sequential fetch
      ifa.en = 1'b1;
      repeat (3) cycle();
      check("seq_pc", ifa.pc, 32'hC);
      check("seq_pred_taken", ifa.pred_taken, 1'b0);

      // Allocate 0x10 -> 0x40 via mispredict
      ifa.en = 1'b0;
      set_res(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
      #1 check("alloc_mispredict", ifa.mispredict, 1'b1);
      cycle();
      check("alloc_redirect", ifa.pc, 32'h40);
      set_res(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h10);
      cycle();
      set_res(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1 check("alloc_pred_taken", ifa.pred_taken, 1'b1);
      check("alloc_pred_target", ifa.pred_target, 32'h40);

      // Two not-taken resolutions walk the counter 2 -> 1 -> 0
      set_res(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
      cycle();
      set_res(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
      #1 check("nt2_no_mispredict", ifa.mispredict, 1'b0);
      cycle();
      set_res(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h10);
      cycle();
      set_res(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1 check("nt_pc", ifa.pc, 32'h10);
      check("nt_pred_taken", ifa.pred_taken, 1'b0);

      // Redirect during stall
      set_res(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h30);
      cycle();
      check("stall_redirect", ifa.pc, 32'h24);

      // Alias 0x50 overwrites the 0x10 entry
      set_res(1'b1, 32'h50, 1'b1, 32'h80, 1'b0, 32'h54);
      cycle();
      check("alias_redirect", ifa.pc, 32'h80);
      set_res(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h10);
      cycle();
      set_res(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1 check("alias_miss_taken", ifa.pred_taken, 1'b0);
      check("alias_miss_target", ifa.pred_target, 32'h14);
      set_res(1'b1, 32'h4C, 1'b0, 32'h0, 1'b1, 32'h50);
      cycle();
      set_res(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1 check("alias_hit_taken", ifa.pred_taken, 1'b1);
      check("alias_hit_target", ifa.pred_target, 32'h80);

      // Statistics: 8 mispredicts and 9 resolutions so far
      check("mispred_cnt_total", mis_a, 32'd8);
      check("branch_cnt_total", br_a, 32'd9);
      check("small_mispred_sat", mis_b, 2'd3);
      check("small_pc_follows", ifb.pc, 32'h50);

      // Wrap-around of res_pc + 4
      set_res(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h8);
      cycle();
      check("wrap_pc", ifa.pc, 32'h0);

      // Odd taken target loads with bit 0 cleared
      set_res(1'b1, 32'h100, 1'b1, 32'h203, 1'b0, 32'h104);
      cycle();
      check("odd_target_pc", ifa.pc, 32'h202);

      // Reset in the middle of a pending redirect
      set_res(1'b1, 32'h30, 1'b1, 32'h300, 1'b0, 32'h34);
      #2 nrst = 1'b0;
      @(posedge clk);
      #1 check("rst_mid_pc", ifa.pc, 32'h0);
      @(negedge clk);
      set_res(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      nrst = 1'b1;
      m_reset();
      #1 check("rst_mid_pred_taken", ifa.pred_taken, 1'b0);
      check("rst_mid_pred_target", ifa.pred_target, 32'h4);
      check("rst_mid_cnt", mis_b, 2'd0);

      // Randomized traffic over an aliasing address range
      for (int n = 0; n < 400; n++) begin
         ifa.en = 1'($urandom_range(0, 1));
         rv     = ($urandom_range(0, 2) == 0);
         rpc    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : $urandom_range(0, 47) * 4;
         rt     = 1'($urandom_range(0, 1));
         rtgt   = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0)
            set_res(rv, rpc, rt, rtgt, m_ptaken(rpc), m_ptgt(rpc));
         else
            set_res(rv, rpc, rt, rtgt, 1'($urandom_range(0, 1)), $urandom_range(0, 255));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
